fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 SHALL provide parameter IMEM_BYTES, default 128, size in bytes of the instruction store; addresses >= IMEM_BYTES are out of range.
REQ-003 SHALL provide parameter NOP_INST, default 32'h0000_0013, the bubble instruction (addi x0,x0,0).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port imemAddr  output  32  byte address driven to the instruction memory.
REQ-007 SHALL have port imemInst  input  32  instruction returned combinationally for imemAddr, same cycle.
REQ-008 SHALL have port stall  input  1  hazard unit hold request; freezes PC and IF/ID.
REQ-009 SHALL have port redirect  input  1  taken branch/jump resolved downstream; flushes IF/ID.
REQ-010 SHALL have port redirectTarget  input  32  new PC when redirect=1.
REQ-011 SHALL have port pcD  output  32  registered PC of the instruction in IF/ID.
REQ-012 SHALL have port instD  output  32  registered instruction in IF/ID.
REQ-013 SHALL have port validD  output  1  IF/ID holds a real fetched instruction.
REQ-014 SHALL have port fetchFault  output  1  sticky misaligned-redirect indication.
REQ-015 SHALL have port halted  output  1  fetch stopped because PC left the instruction store.
REQ-016 SHALL have port fetchCount  output  32  number of instructions captured into IF/ID.

Function
REQ-017 SHALL hold a 32-bit PC register and drive imemAddr = PC combinationally at all times.
REQ-018 SHALL implement states RUN, HALT, FAULT; halted = (state==HALT), fetchFault = (state==FAULT).
REQ-019 SHALL, in RUN with PC < IMEM_BYTES, stall=0, redirect=0: capture pcD<=PC, instD<=imemInst, validD<=1, PC<=PC+4, fetchCount<=fetchCount+1 at the clock edge (one-cycle fetch latency).
REQ-020 SHALL, on stall=1 and redirect=0 in any state: hold PC, pcD, instD, validD, fetchCount, state unchanged.
REQ-021 SHALL give redirect priority over stall; redirect=1 with redirectTarget[1:0]==0 in RUN or HALT: PC<=redirectTarget, instD<=NOP_INST, validD<=0, pcD unchanged, state<=RUN, no count.
REQ-022 SHALL, on redirect=1 with redirectTarget[1:0]!=0 in any state: PC held, IF/ID loaded with bubble, state<=FAULT.
REQ-023 SHALL, in RUN with PC >= IMEM_BYTES (no redirect, no stall): load bubble into IF/ID, hold PC, state<=HALT; imemInst ignored.
REQ-024 SHALL, in HALT without redirect: hold PC, keep bubble in IF/ID (validD=0), no count.
REQ-025 SHALL, in FAULT: ignore stall and redirect, hold PC, keep bubble in IF/ID; exit only via reset.
REQ-026 SHALL compute PC+4 modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is permitted (out-of-range rule applies first).
REQ-027 SHALL wrap fetchCount from 32'hFFFF_FFFF to 0 silently.
REQ-028 SHALL treat a redirect whose target >= IMEM_BYTES as a legal redirect; the following RUN cycle enters HALT per REQ-023.

Reset
REQ-029 SHALL, while rst_n=0, asynchronously force PC=RESET_PC, pcD=0, instD=NOP_INST, validD=0, fetchCount=0, state=RUN; halted=0, fetchFault=0.
REQ-030 SHALL resume fetch at RESET_PC on the first rising clk after rst_n deasserts; assertion mid-operation discards IF/ID contents and any pending redirect.

Verification
REQ-031 Reset then 4 free-running cycles, imem words at 0,4,8,12 -> pcD 0,4,8,12 with matching instD, validD=1 each, fetchCount=4, PC=16.
REQ-032 stall=1 for 3 cycles at PC=8 -> PC, pcD, instD, fetchCount unchanged; release -> capture of address 8 next edge.
REQ-033 redirect=1, stall=1, target=0x20 at PC=12 -> PC=0x20, instD=0x00000013, validD=0; next edge pcD=0x20, validD=1.
REQ-034 run to PC=124 -> capture 124, then PC=128 -> next edge halted=1, validD=0, PC stays 128; redirect to 0 -> halted=0, fetch resumes at 0.
REQ-035 redirect target=0x0000_0006 -> fetchFault=1, validD=0, PC held; further redirects to 0 ignored; rst_n=0 clears fetchFault and PC=RESET_PC immediately (no clock).

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and
// run/halt/fault control for a single-cycle combinational instruction store.
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 128,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imemAddr,
    input  logic [31:0] imemInst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirectTarget,
    output logic [31:0] pcD,
    output logic [31:0] instD,
    output logic        validD,
    output logic        fetchFault,
    output logic        halted,
    output logic [31:0] fetchCount
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HALT  = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [31:0] IMEM_LIM = 32'(IMEM_BYTES);

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc;
    logic        in_range;
    logic        aligned;
    logic        live;
    logic        good_redir;
    logic        bad_redir;
    logic        do_fetch;
    logic        out_of_range;
    logic        act_fetch;
    logic        act_bubble;
    logic        act_jump;

    assign imemAddr = pc;
    assign in_range = (pc < IMEM_LIM);
    assign aligned  = (redirectTarget[1:0] == 2'b00);

    // Mutually exclusive conditions; FAULT masks every input.
    assign live         = (state != FAULT);
    assign good_redir   = live && redirect && aligned;
    assign bad_redir    = live && redirect && !aligned;
    assign do_fetch     = (state == RUN) && !redirect && !stall && in_range;
    assign out_of_range = (state == RUN) && !redirect && !stall && !in_range;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        act_fetch  = 1'b0;
        act_bubble = 1'b0;
        act_jump   = 1'b0;
        unique case (1'b1)
            bad_redir: begin
                act_bubble = 1'b1;
                state_nx   = FAULT;
            end
            good_redir: begin
                act_bubble = 1'b1;
                act_jump   = 1'b1;
                state_nx   = RUN;
            end
            do_fetch: begin
                act_fetch = 1'b1;
            end
            out_of_range: begin
                act_bubble = 1'b1;
                state_nx   = HALT;
            end
            default: begin
                state_nx = state;
            end
        endcase
    end

    always_comb begin
        halted     = (state == HALT);
        fetchFault = (state == FAULT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            pcD        <= 32'h0;
            instD      <= NOP_INST;
            validD     <= 1'b0;
            fetchCount <= 32'h0;
        end else if (act_fetch) begin
            pc         <= pc + 32'd4;
            pcD        <= pc;
            instD      <= imemInst;
            validD     <= 1'b1;
            fetchCount <= fetchCount + 32'd1;
        end else if (act_bubble) begin
            instD  <= NOP_INST;
            validD <= 1'b0;
            if (act_jump) begin
                pc <= redirectTarget;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios with literal expectations
// plus randomized traffic compared against a behavioural model.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] imemAddr;
    logic [31:0] imemInst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectTarget;
    logic [31:0] pcD;
    logic [31:0] instD;
    logic        validD;
    logic        fetchFault;
    logic        halted;
    logic [31:0] fetchCount;

    logic [31:0] mem [32];

    int checks;
    int errors;
    bit check_en;

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imemAddr      (imemAddr),
        .imemInst      (imemInst),
        .stall         (stall),
        .redirect      (redirect),
        .redirectTarget(redirectTarget),
        .pcD           (pcD),
        .instD         (instD),
        .validD        (validD),
        .fetchFault    (fetchFault),
        .halted        (halted),
        .fetchCount    (fetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imemInst = (imemAddr < 32'd128) ? mem[imemAddr[6:2]]
                                           : (imemAddr ^ 32'hA5A5_5A5A);

    // Behavioural model: rules applied in priority order each edge.
    logic [31:0] m_pc, m_pcd, m_inst, m_cnt;
    logic        m_valid, m_halt, m_fault;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= 32'h0;
            m_pcd   <= 32'h0;
            m_inst  <= NOP;
            m_valid <= 1'b0;
            m_cnt   <= 32'h0;
            m_halt  <= 1'b0;
            m_fault <= 1'b0;
        end else if (m_fault) begin
            m_fault <= 1'b1;
        end else if (redirect) begin
            m_inst  <= NOP;
            m_valid <= 1'b0;
            m_halt  <= 1'b0;
            if (redirectTarget[1:0] != 2'b00) begin
                m_fault <= 1'b1;
            end else begin
                m_pc <= redirectTarget;
            end
        end else if (stall || m_halt) begin
            m_halt <= m_halt;
        end else if (m_pc >= 32'd128) begin
            m_halt  <= 1'b1;
            m_inst  <= NOP;
            m_valid <= 1'b0;
        end else begin
            m_pcd   <= m_pc;
            m_inst  <= mem[m_pc[6:2]];
            m_valid <= 1'b1;
            m_pc    <= m_pc + 32'd4;
            m_cnt   <= m_cnt + 32'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("m.imemAddr", imemAddr, m_pc);
            chk("m.pcD", pcD, m_pcd);
            chk("m.instD", instD, m_inst);
            chk("m.validD", 32'(validD), 32'(m_valid));
            chk("m.fetchCount", fetchCount, m_cnt);
            chk("m.halted", 32'(halted), 32'(m_halt));
            chk("m.fetchFault", 32'(fetchFault), 32'(m_fault));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        tick();
        rst_n    = 1'b0;
        stall    = 1'b0;
        redirect = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        check_en       = 1'b0;
        rst_n          = 1'b1;
        stall          = 1'b0;
        redirect       = 1'b0;
        redirectTarget = 32'h0;
        for (int i = 0; i < 32; i++) mem[i] = $urandom;
        #1 rst_n = 1'b0;
        #2;
        chk("rst.imemAddr", imemAddr, 32'h0);
        chk("rst.pcD", pcD, 32'h0);
        chk("rst.instD", instD, NOP);
        chk("rst.validD", 32'(validD), 32'h0);
        chk("rst.fetchCount", fetchCount, 32'h0);
        chk("rst.halted", 32'(halted), 32'h0);
        chk("rst.fetchFault", 32'(fetchFault), 32'h0);
        tick();
        rst_n    = 1'b1;
        check_en = 1'b1;

        for (int i = 0; i < 4; i++) begin
            tick();
            chk("run.pcD", pcD, 32'(i * 4));
            chk("run.instD", instD, mem[i]);
            chk("run.validD", 32'(validD), 32'h1);
        end
        chk("run.fetchCount", fetchCount, 32'd4);
        chk("run.pc", imemAddr, 32'd16);

        do_reset();
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall.pc", imemAddr, 32'd8);
            chk("stall.pcD", pcD, 32'd4);
            chk("stall.instD", instD, mem[1]);
            chk("stall.fetchCount", fetchCount, 32'd2);
        end
        stall = 1'b0;
        tick();
        chk("unstall.pcD", pcD, 32'd8);
        chk("unstall.instD", instD, mem[2]);

        redirect       = 1'b1;
        stall          = 1'b1;
        redirectTarget = 32'h20;
        tick();
        chk("redir.pc", imemAddr, 32'h20);
        chk("redir.instD", instD, 32'h0000_0013);
        chk("redir.validD", 32'(validD), 32'h0);
        chk("redir.pcD", pcD, 32'd8);
        chk("redir.fetchCount", fetchCount, 32'd3);
        redirect = 1'b0;
        stall    = 1'b0;
        tick();
        chk("redir2.pcD", pcD, 32'h20);
        chk("redir2.validD", 32'(validD), 32'h1);

        redirect       = 1'b1;
        redirectTarget = 32'd124;
        tick();
        redirect = 1'b0;
        chk("edge.pc", imemAddr, 32'd124);
        tick();
        chk("edge.pcD", pcD, 32'd124);
        chk("edge.instD", instD, mem[31]);
        chk("edge.pc128", imemAddr, 32'd128);
        tick();
        chk("halt.halted", 32'(halted), 32'h1);
        chk("halt.validD", 32'(validD), 32'h0);
        chk("halt.pc", imemAddr, 32'd128);
        tick();
        chk("halt2.halted", 32'(halted), 32'h1);
        chk("halt2.pc", imemAddr, 32'd128);
        redirect       = 1'b1;
        redirectTarget = 32'h0;
        tick();
        redirect = 1'b0;
        chk("unhalt.halted", 32'(halted), 32'h0);
        chk("unhalt.pc", imemAddr, 32'h0);
        tick();
        chk("unhalt.pcD", pcD, 32'h0);
        chk("unhalt.validD", 32'(validD), 32'h1);

        redirect       = 1'b1;
        redirectTarget = 32'h0000_0006;
        tick();
        chk("fault.flag", 32'(fetchFault), 32'h1);
        chk("fault.validD", 32'(validD), 32'h0);
        chk("fault.pc", imemAddr, 32'd4);
        redirectTarget = 32'h0;
        for (int i = 0; i < 2; i++) begin
            stall = 1'(i);
            tick();
            chk("fault.sticky", 32'(fetchFault), 32'h1);
            chk("fault.pcheld", imemAddr, 32'd4);
        end
        redirect = 1'b0;
        stall    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst.fetchFault", 32'(fetchFault), 32'h0);
        chk("arst.pc", imemAddr, 32'h0);
        chk("arst.halted", 32'(halted), 32'h0);
        tick();
        rst_n = 1'b1;

        redirectTarget = 32'hFFFF_FFFC;
        redirect       = 1'b1;
        tick();
        redirect = 1'b0;
        tick();
        chk("top.halted", 32'(halted), 32'h1);
        chk("top.pc", imemAddr, 32'hFFFF_FFFC);

        for (int i = 0; i < 3000; i++) begin
            tick();
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 59) == 0) begin
                rst_n = 1'b0;
            end
            stall    = ($urandom_range(0, 3) == 0);
            redirect = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 19))
                0: redirectTarget = (32'($urandom_range(0, 40)) << 2)
                                  | 32'($urandom_range(1, 3));
                1: redirectTarget = 32'hFFFF_FFFC;
                default: redirectTarget = 32'($urandom_range(0, 40)) << 2;
            endcase
        end
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
